// File: rtl/cam_init_seq_pkg.sv
// Shared definitions for the camera init sequencer: table markers, FSM states
// and the {reg, data} table entry layout.
package cam_pkg;

    localparam logic [15:0] CAM_REG_DELAY = 16'hFFFF;
    localparam logic [15:0] CAM_REG_END   = 16'hFFFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP,
        ST_DELAY,
        ST_DONE
    } cam_state_t;

    typedef struct packed {
        logic [15:0] reg_addr;
        logic [7:0]  data;
    } cam_entry_t;

    function automatic cam_entry_t cam_entry(input logic [15:0] r, input logic [7:0] d);
        cam_entry_t e;
        e.reg_addr = r;
        e.data     = d;
        return e;
    endfunction

endpackage

// File: rtl/cam_init_seq_if.sv
// Bus between the init sequencer and the I2C write engine.
interface cam_init_seq_if;

    logic        send_data;
    logic [15:0] register_out;
    logic [7:0]  data_out;
    logic [6:0]  slave_addr;

    modport master (
        output send_data,
        output register_out,
        output data_out,
        output slave_addr
    );

    modport slave (
        input send_data,
        input register_out,
        input data_out,
        input slave_addr
    );

endinterface

// File: rtl/cam_init_seq_rom.sv
// Synchronous register-table ROM; holds the sensor bring-up table unless a
// replacement table is supplied through USE_INIT/INIT.
module cam_init_rom
    import cam_pkg::*;
#(
    parameter int unsigned                 TABLE_DEPTH = 64,
    parameter bit                          USE_INIT    = 1'b0,
    parameter logic [TABLE_DEPTH*24-1:0]   INIT        = '0
) (
    input  logic                           clk,
    input  logic [$clog2(TABLE_DEPTH)-1:0] addr,
    output cam_entry_t                     q
);

    function automatic cam_entry_t sensor_entry(input int unsigned i);
        case (i)
            0:       return cam_entry(16'h0103, 8'h01);
            1:       return cam_entry(CAM_REG_DELAY, 8'h0A);
            2:       return cam_entry(16'h0100, 8'h00);
            3:       return cam_entry(16'h30EB, 8'h05);
            4:       return cam_entry(16'h30EB, 8'h0C);
            5:       return cam_entry(16'h300A, 8'hFF);
            6:       return cam_entry(16'h300B, 8'hFF);
            7:       return cam_entry(16'h30EB, 8'h05);
            8:       return cam_entry(16'h30EB, 8'h09);
            9:       return cam_entry(16'h0114, 8'h01);
            10:      return cam_entry(16'h0128, 8'h00);
            11:      return cam_entry(16'h012A, 8'h18);
            12:      return cam_entry(16'h012B, 8'h00);
            13:      return cam_entry(16'h0160, 8'h04);
            14:      return cam_entry(16'h0100, 8'h01);
            default: return cam_entry(CAM_REG_END, 8'h00);
        endcase
    endfunction

    cam_entry_t mem [TABLE_DEPTH];

    for (genvar i = 0; i < TABLE_DEPTH; i++) begin : g_mem
        assign mem[i] = USE_INIT ? cam_entry_t'(INIT[i*24 +: 24]) : sensor_entry(i);
    end

    always_ff @(posedge clk) begin
        q <= mem[addr];
    end

endmodule

// File: rtl/cam_init_seq.sv
// Camera register-initialisation sequencer: walks the ROM table, presents each
// write to the I2C engine with a fixed post-write gap, honours delay/end markers.
module cam_init_seq
    import cam_pkg::*;
#(
    parameter logic [6:0]                SLAVE_ADDR     = 7'h10,
    parameter int unsigned               TABLE_DEPTH    = 64,
    parameter int unsigned               GAP_CYCLES     = 48,
    parameter int unsigned               DELAY_UNIT     = 400,
    parameter bit                        USE_TEST_TABLE = 1'b0,
    parameter logic [TABLE_DEPTH*24-1:0] TEST_TABLE     = '0
) (
    input  logic                           clk400kHz,
    input  logic                           reset,
    input  logic                           start,
    cam_init_seq_if.master                 i2c,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(TABLE_DEPTH)-1:0] index
);

    localparam int unsigned      IDX_W    = $clog2(TABLE_DEPTH);
    localparam int unsigned      CNT_W    = 8 + $clog2(DELAY_UNIT) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TABLE_DEPTH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] UNIT     = CNT_W'(DELAY_UNIT);

    cam_state_t       state_q, state_d;
    logic             start_q;
    logic             start_edge;
    logic [IDX_W-1:0] index_q, index_d;
    logic             exhausted_q, exhausted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      reg_q, reg_d;
    logic [7:0]       data_q, data_d;
    cam_entry_t       rom_q;

    cam_init_rom #(
        .TABLE_DEPTH (TABLE_DEPTH),
        .USE_INIT    (USE_TEST_TABLE),
        .INIT        (TEST_TABLE)
    ) u_rom (
        .clk  (clk400kHz),
        .addr (index_q),
        .q    (rom_q)
    );

    assign start_edge = start & ~start_q;

    always_ff @(posedge clk400kHz or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            index_q     <= '0;
            exhausted_q <= 1'b0;
            cnt_q       <= '0;
            reg_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            index_q     <= index_d;
            exhausted_q <= exhausted_d;
            cnt_q       <= cnt_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
        end
    end

    // Running off the table end keeps index at the last slot and flags the
    // next DECODE to behave exactly like a fetched end marker.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        exhausted_d = exhausted_q;
        cnt_d       = cnt_q;
        reg_d       = reg_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    index_d     = '0;
                    exhausted_d = 1'b0;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (exhausted_q || rom_q.reg_addr == CAM_REG_END) begin
                    state_d = ST_DONE;
                end else if (rom_q.reg_addr == CAM_REG_DELAY) begin
                    cnt_d   = CNT_W'(rom_q.data) * UNIT;
                    state_d = ST_DELAY;
                end else begin
                    reg_d   = rom_q.reg_addr;
                    data_d  = rom_q.data;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: state_d = ST_STROBE;
            ST_STROBE: begin
                cnt_d   = GAP_LOAD;
                state_d = ST_GAP;
            end
            ST_GAP, ST_DELAY: begin
                if (cnt_q == '0) begin
                    if (index_q == IDX_LAST) begin
                        exhausted_d = 1'b1;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign i2c.send_data    = (state_q == ST_STROBE);
    assign i2c.register_out = reg_q;
    assign i2c.data_out     = data_q;
    assign i2c.slave_addr   = SLAVE_ADDR;

    assign busy  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done  = (state_q == ST_DONE);
    assign index = index_q;

endmodule

// File: tb/tb_cam_init_seq.sv
// Randomised scoreboard bench for cam_init_seq: three instances with test
// tables, expected strobes/done predicted from the table rules.
module tb_cam_init_seq;

    localparam int GAP  = 48;
    localparam int UNIT = 400;

    // entry 0 sits in the least significant 24 bits
    localparam logic [64*24-1:0] TBL_A = {{62{24'hFFFE00}}, 24'hFFFE00, 24'h30125A};
    localparam logic [64*24-1:0] TBL_B = {{56{24'hFFFE00}}, 24'hFFFE00, 24'h011401,
                                          24'hFFFF00, 24'h300AFF, 24'h30EB0C,
                                          24'h010301, 24'hFFFF05, 24'h010001};
    localparam logic [4*24-1:0]  TBL_C = {24'h020444, 24'h020333, 24'h020222, 24'h020111};

    typedef struct {
        int          dut;
        bit          is_done;
        int          cyc;
        logic [15:0] r;
        logic [7:0]  dat;
        logic [5:0]  idx;
    } exp_t;

    typedef struct {
        int          dut;
        int          cyc;
        logic        snd;
        logic        bsy;
        logic        dn;
        logic [5:0]  idx;
        bit          chk_bus;
        logic [15:0] r;
        logic [7:0]  dat;
    } probe_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    exp_t   exp_q[$];
    probe_t pr_q[$];

    logic        start_v [3];
    logic        rst_v   [3];
    logic        snd     [3];
    logic [15:0] rgo     [3];
    logic [7:0]  dto     [3];
    logic [6:0]  sla     [3];
    logic        bsy     [3];
    logic        dn      [3];
    logic [5:0]  idx     [3];
    logic [5:0]  idx_a, idx_b;
    logic [1:0]  idx_c;

    cam_init_seq_if bus_a ();
    cam_init_seq_if bus_b ();
    cam_init_seq_if bus_c ();

    cam_init_seq #(.TABLE_DEPTH(64), .GAP_CYCLES(GAP), .DELAY_UNIT(UNIT),
                   .USE_TEST_TABLE(1'b1), .TEST_TABLE(TBL_A)) dut_a (
        .clk400kHz(clk), .reset(rst_v[0]), .start(start_v[0]), .i2c(bus_a),
        .busy(bsy[0]), .done(dn[0]), .index(idx_a));

    cam_init_seq #(.TABLE_DEPTH(64), .GAP_CYCLES(GAP), .DELAY_UNIT(UNIT),
                   .USE_TEST_TABLE(1'b1), .TEST_TABLE(TBL_B)) dut_b (
        .clk400kHz(clk), .reset(rst_v[1]), .start(start_v[1]), .i2c(bus_b),
        .busy(bsy[1]), .done(dn[1]), .index(idx_b));

    cam_init_seq #(.TABLE_DEPTH(4), .GAP_CYCLES(GAP), .DELAY_UNIT(UNIT),
                   .USE_TEST_TABLE(1'b1), .TEST_TABLE(TBL_C)) dut_c (
        .clk400kHz(clk), .reset(rst_v[2]), .start(start_v[2]), .i2c(bus_c),
        .busy(bsy[2]), .done(dn[2]), .index(idx_c));

    assign snd[0] = bus_a.send_data;    assign snd[1] = bus_b.send_data;    assign snd[2] = bus_c.send_data;
    assign rgo[0] = bus_a.register_out; assign rgo[1] = bus_b.register_out; assign rgo[2] = bus_c.register_out;
    assign dto[0] = bus_a.data_out;     assign dto[1] = bus_b.data_out;     assign dto[2] = bus_c.data_out;
    assign sla[0] = bus_a.slave_addr;   assign sla[1] = bus_b.slave_addr;   assign sla[2] = bus_c.slave_addr;
    assign idx[0] = idx_a;
    assign idx[1] = idx_b;
    assign idx[2] = {4'b0000, idx_c};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] tbl_entry(input int d, input int i);
        logic [64*24-1:0] t;
        case (d)
            0:       t = TBL_A;
            1:       t = TBL_B;
            default: t = {{(60*24){1'b0}}, TBL_C};
        endcase
        return t[i*24 +: 24];
    endfunction

    // Reference timing: a write occupies fetch/decode/setup/strobe plus the gap,
    // a delay entry occupies fetch/decode plus data*UNIT+1, the end marker is
    // fetched and decoded before done rises.
    task automatic predict(input int d, input int s);
        int          t;
        int          depth;
        logic [23:0] e;
        logic [15:0] lr;
        logic [7:0]  ld;
        bit          ended;
        exp_t        ev;
        t = s + 1;
        depth = (d == 2) ? 4 : 64;
        lr = '0;
        ld = '0;
        ended = 1'b0;
        for (int i = 0; i < depth && !ended; i++) begin
            e = tbl_entry(d, i);
            if (e[23:8] == 16'hFFFE) begin
                ev = '{dut: d, is_done: 1'b1, cyc: t + 2, r: lr, dat: ld, idx: 6'(i)};
                exp_q.push_back(ev);
                ended = 1'b1;
            end else if (e[23:8] == 16'hFFFF) begin
                t = t + 3 + int'(e[7:0]) * UNIT;
            end else begin
                lr = e[23:8];
                ld = e[7:0];
                ev = '{dut: d, is_done: 1'b0, cyc: t + 3, r: lr, dat: ld, idx: 6'(i)};
                exp_q.push_back(ev);
                t = t + GAP + 4;
            end
        end
        if (!ended) begin
            ev = '{dut: d, is_done: 1'b1, cyc: t + 2, r: lr, dat: ld, idx: 6'(depth - 1)};
            exp_q.push_back(ev);
        end
    endtask

    task automatic push_probe(input int d, input int c, input logic s, input logic b,
                              input logic n, input logic [5:0] ix, input bit cb,
                              input logic [15:0] r, input logic [7:0] dt);
        probe_t p;
        p = '{dut: d, cyc: c, snd: s, bsy: b, dn: n, idx: ix, chk_bus: cb, r: r, dat: dt};
        pr_q.push_back(p);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 6000;
        while ((exp_q.size() > 0 || pr_q.size() > 0) && budget > 0) begin
            tick(1);
            budget--;
        end
        if (budget == 0) begin
            $display("FAIL drain: %0d events %0d probes still pending, required 0", exp_q.size(), pr_q.size());
            $fatal(1, "scoreboard did not drain");
        end
    endtask

    task automatic launch(input int d, input bit spurious);
        int s;
        tick($urandom_range(1, 20));
        s = cyc;
        predict(d, s);
        push_probe(d, s + 1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 16'h0, 8'h0);
        start_v[d] = 1'b1;
        tick($urandom_range(1, 3));
        start_v[d] = 1'b0;
        if (spurious) begin
            tick($urandom_range(2, 30));
            start_v[d] = 1'b1;
            tick(1);
            start_v[d] = 1'b0;
        end
    endtask

    // Scoreboard monitor
    exp_t        mev;
    probe_t      mp;
    int          gap_left [3];
    logic [15:0] last_r   [3];
    logic [7:0]  last_d   [3];
    logic        dn_prev  [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            gap_left[d] = 0;
            last_r[d]   = '0;
            last_d[d]   = '0;
            dn_prev[d]  = 1'b0;
        end
    end

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mev = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL %s dut%0d: nothing seen, required at cycle %0d",
                     mev.is_done ? "done" : "strobe", mev.dut, mev.cyc);
        end
        for (int d = 0; d < 3; d++) begin
            if (!rst_v[d]) gap_left[d] = 0;
            if (snd[d]) begin
                compared++;
                if (exp_q.size() == 0 || exp_q[0].is_done || exp_q[0].dut != d) begin
                    mismatched++;
                    $display("FAIL strobe dut%0d: unexpected at cycle %0d reg=%h data=%h, required none",
                             d, cyc, rgo[d], dto[d]);
                end else begin
                    mev = exp_q.pop_front();
                    if (mev.cyc != cyc || rgo[d] != mev.r || dto[d] != mev.dat || sla[d] != 7'h10) begin
                        mismatched++;
                        $display("FAIL strobe dut%0d: got cyc=%0d reg=%h data=%h sla=%h, required cyc=%0d reg=%h data=%h sla=10",
                                 d, cyc, rgo[d], dto[d], sla[d], mev.cyc, mev.r, mev.dat);
                    end
                end
                last_r[d]   = rgo[d];
                last_d[d]   = dto[d];
                gap_left[d] = GAP;
            end else if (gap_left[d] > 0) begin
                gap_left[d]--;
                compared++;
                if (rgo[d] != last_r[d] || dto[d] != last_d[d]) begin
                    mismatched++;
                    $display("FAIL bus_hold dut%0d cyc=%0d: got reg=%h data=%h, required reg=%h data=%h",
                             d, cyc, rgo[d], dto[d], last_r[d], last_d[d]);
                end
            end
            if (dn[d] && !dn_prev[d]) begin
                compared++;
                if (exp_q.size() == 0 || !exp_q[0].is_done || exp_q[0].dut != d) begin
                    mismatched++;
                    $display("FAIL done dut%0d: unexpected rise at cycle %0d, required none", d, cyc);
                end else begin
                    mev = exp_q.pop_front();
                    if (mev.cyc != cyc || bsy[d] !== 1'b0 || idx[d] != mev.idx ||
                        rgo[d] != mev.r || dto[d] != mev.dat) begin
                        mismatched++;
                        $display("FAIL done dut%0d: got cyc=%0d busy=%b index=%0d reg=%h data=%h, required cyc=%0d busy=0 index=%0d reg=%h data=%h",
                                 d, cyc, bsy[d], idx[d], rgo[d], dto[d], mev.cyc, mev.idx, mev.r, mev.dat);
                    end
                end
            end
            dn_prev[d] = dn[d];
        end
        while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
            mp = pr_q.pop_front();
            compared++;
            if (mp.cyc != cyc || snd[mp.dut] !== mp.snd || bsy[mp.dut] !== mp.bsy ||
                dn[mp.dut] !== mp.dn || idx[mp.dut] != mp.idx ||
                (mp.chk_bus && (rgo[mp.dut] != mp.r || dto[mp.dut] != mp.dat))) begin
                mismatched++;
                $display("FAIL probe dut%0d cyc=%0d: got send=%b busy=%b done=%b index=%0d reg=%h data=%h, required cyc=%0d send=%b busy=%b done=%b index=%0d reg=%h data=%h",
                         mp.dut, cyc, snd[mp.dut], bsy[mp.dut], dn[mp.dut], idx[mp.dut],
                         rgo[mp.dut], dto[mp.dut], mp.cyc, mp.snd, mp.bsy, mp.dn, mp.idx, mp.r, mp.dat);
            end
        end
    end

    initial begin
        int r;
        for (int d = 0; d < 3; d++) begin
            start_v[d] = 1'b0;
            rst_v[d]   = 1'b0;
        end
        tick(2);
        for (int d = 0; d < 3; d++)
            push_probe(d, cyc, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0, 8'h0);
        tick(1);
        for (int d = 0; d < 3; d++) rst_v[d] = 1'b1;
        tick(2);

        // single write then end; restarts after done, one with an extra start while busy
        for (int rep = 0; rep < 3; rep++) begin
            launch(0, rep == 1);
            wait_drain();
        end

        // writes, 5-unit delay, back-to-back writes, zero delay
        for (int rep = 0; rep < 2; rep++) begin
            launch(1, rep == 1);
            wait_drain();
        end

        // depth-4 table without end marker: stops after the fourth write
        for (int rep = 0; rep < 2; rep++) begin
            launch(2, rep == 0);
            wait_drain();
            push_probe(2, cyc + 1, 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 16'h0204, 8'h44);
            tick(60);
            push_probe(2, cyc + 1, 1'b0, 1'b0, 1'b1, 6'd3, 1'b1, 16'h0204, 8'h44);
            wait_drain();
        end

        // reset asserted between the first strobe and the end of its gap
        launch(1, 1'b0);
        r = cyc + 3 + $urandom_range(0, GAP);
        tick(r - cyc);
        rst_v[1] = 1'b0;
        exp_q.delete();
        push_probe(1, cyc, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0, 8'h0);
        tick($urandom_range(1, 5));
        rst_v[1] = 1'b1;
        tick(80);
        push_probe(1, cyc + 1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 16'h0, 8'h0);
        wait_drain();

        launch(1, 1'b0);
        wait_drain();
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
